pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush/halt controller for the parametrised in-order RISC-V pipeline (IF,ID,EX,MEM..WB).
//  Generalises the fixed 5-stage load-use/flush logic to NSTAGE stages, multi-cycle load latency,
//  a per-stage valid vector, a halt/drain/resume state machine and a retired-instruction counter.
//  Sits beside the datapath; drives the PC hold, IF/ID hold/flush and ID/EX bubble controls.
// PARAMETERS
//  NSTAGE     5  pipeline depth; index 0=IF,1=ID,2=EX,NSTAGE-1=WB; legal range 4..8
//  RF_ADDRESS 5  register-file address width
//  LOAD_LAT   1  stall cycles inserted per load-use hazard; legal range 1..7
//  CNT_W      32 width of retired-instruction counter
// PORTS
//  clk          in  1          clock, all state on rising edge
//  reset        in  1          asynchronous, active-low (0 = reset)
//  id_rs1       in  RF_ADDRESS rs1 of instruction in ID
//  id_rs2       in  RF_ADDRESS rs2 of instruction in ID
//  id_use_rs1   in  1          ID instruction reads rs1
//  id_use_rs2   in  1          ID instruction reads rs2
//  id_halt      in  1          ID instruction is a halt (ebreak) instruction
//  ex_rd        in  RF_ADDRESS rd of instruction in EX
//  ex_memread   in  1          EX instruction is a load
//  ex_redirect  in  1          EX branch taken / jal / jalr (PcSel)
//  resume       in  1          single-cycle pulse, leave HALTED
//  stall_pc     out 1          hold PC register
//  stall_ifid   out 1          hold IF/ID register
//  flush_ifid   out 1          clear IF/ID register
//  bubble_idex  out 1          load NOP into ID/EX register
//  stage_valid  out NSTAGE     valid bit per stage
//  halted       out 1          state == HALTED
//  retire       out 1          = stage_valid[NSTAGE-1]
//  retire_cnt   out CNT_W      retired-instruction count
// BEHAVIOUR
//  Reset (reset=0, async): state=RUN, stage_valid=0, stall_cnt=0, retire_cnt=0; all outputs 0.
//  Control outputs combinational from state/registers/inputs (0-cycle); valid/counters update next edge.
//  hazard = v[1] & v[2] & ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd)|(id_use_rs2 & id_rs2==ex_rd)).
//  lu_stall = hazard | (stall_cnt!=0). On hazard with stall_cnt==0: stall_cnt<=LOAD_LAT-1; else decrements to 0.
//  lu_stall: stall_pc=stall_ifid=bubble_idex=1; v[1],v[0] hold; v[2]<=0; v[i]<=v[i-1] for i>=3.
//  ex_redirect (priority over lu_stall): flush_ifid=bubble_idex=1, stall_pc=0; v[1]<=0, v[2]<=0,
//   v[0]<=1 (RUN), stall_cnt<=0, v[i]<=v[i-1] for i>=3.
//  Normal advance: v[0]<=(state==RUN); v[i]<=v[i-1].
//  FSM RUN->DRAIN: v[1] & id_halt & !lu_stall & !ex_redirect. That cycle: stall_pc=1, flush_ifid=1,
//   halt instr advances to EX; younger instr in IF squashed; PC held at halt+4.
//  DRAIN: stall_pc=1, v[0]<=0, older instrs + halt drain. DRAIN->HALTED when stage_valid==0.
//  HALTED: stall_pc=1, halted=1, v stays 0. resume=1 -> RUN; fetch restarts at held PC (halt+4).
//  resume outside HALTED ignored. id_halt while lu_stall: entry deferred until stall clears.
//  retire_cnt += retire each cycle, wraps modulo 2^CNT_W (no saturation).
//  Reset asserted mid-stall/drain: immediate return to reset values, counter cleared.
// TESTING
//  T1 reset held 3 cycles, release: all outputs 0; stage_valid 00001, 00011, 00111... retire after 5 cycles.
//  T2 lw x5 in EX, add x6,x5,x1 in ID, LOAD_LAT=2: stall_pc/stall_ifid/bubble_idex high exactly 2 cycles.
//  T3 lw x0 in EX, ID reads x0: no stall; lw x5 + ex_redirect same cycle: flush, no stall, stall_cnt=0.
//  T4 ex_redirect=1 one cycle: flush_ifid=bubble_idex=1; next cycle v[1]=v[2]=0, v[0]=1.
//  T5 halt in ID, pipeline full: DRAIN, halted=1 after NSTAGE-1 further cycles, retire_cnt includes halt;
//   resume pulse -> halted=0, v[0]=1 next cycle.
//  T6 CNT_W=4, retire 17 instrs -> retire_cnt=1; async reset mid-DRAIN -> state RUN, all zero.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/halt controller for an NSTAGE in-order pipeline: load-use interlock,
// redirect flush, halt/drain/resume sequencing, per-stage valid bits and a retire counter.
module pipe_hazard_ctrl #(
  parameter int NSTAGE     = 5,
  parameter int RF_ADDRESS = 5,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RF_ADDRESS-1:0] id_rs1,
  input  logic [RF_ADDRESS-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_halt,
  input  logic [RF_ADDRESS-1:0] ex_rd,
  input  logic                  ex_memread,
  input  logic                  ex_redirect,
  input  logic                  resume,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  flush_ifid,
  output logic                  bubble_idex,
  output logic [NSTAGE-1:0]     stage_valid,
  output logic                  halted,
  output logic                  retire,
  output logic [CNT_W-1:0]      retire_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state_reg;
  logic              halted_reg;
  logic [NSTAGE-1:0] valid_reg;
  logic [NSTAGE-1:0] valid_next;
  logic [2:0]        front_next;
  logic [2:0]        stall_cnt_reg;
  logic [2:0]        stall_cnt_next;
  logic [CNT_W-1:0]  cnt_reg;

  logic rs_match;
  logic hazard;
  logic lu_stall;
  logic halt_enter;
  logic run_next;

  assign rs_match = (id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd));
  assign hazard   = valid_reg[1] && valid_reg[2] && ex_memread && (ex_rd != '0) && rs_match;
  assign lu_stall = hazard || (stall_cnt_reg != 3'd0);

  // A halt waits in ID until any load-use stall has finished and no redirect is pending.
  assign halt_enter = (state_reg == RUN) && valid_reg[1] && id_halt && !lu_stall && !ex_redirect;
  assign run_next   = ((state_reg == RUN) && !halt_enter) || ((state_reg == HALTED) && resume);

  assign stall_pc    = (state_reg != RUN) || halt_enter || (lu_stall && !ex_redirect);
  assign stall_ifid  = lu_stall && !ex_redirect;
  assign flush_ifid  = ex_redirect || halt_enter;
  assign bubble_idex = ex_redirect || lu_stall;

  assign stage_valid = valid_reg;
  assign halted      = halted_reg;
  assign retire      = valid_reg[NSTAGE-1];
  assign retire_cnt  = cnt_reg;

  // IF/ID/EX valid bits follow the stall/flush controls; everything past EX just shifts.
  always_comb begin
    front_next     = {valid_reg[1], valid_reg[0], run_next};
    stall_cnt_next = stall_cnt_reg;
    if (ex_redirect) begin
      front_next     = {1'b0, 1'b0, run_next};
      stall_cnt_next = 3'd0;
    end else if (lu_stall) begin
      front_next     = {1'b0, valid_reg[1], valid_reg[0]};
      stall_cnt_next = (stall_cnt_reg == 3'd0) ? 3'(LOAD_LAT - 1) : stall_cnt_reg - 3'd1;
    end else if (halt_enter) begin
      front_next = {valid_reg[1], 2'b00};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSTAGE; gi++) begin : g_valid
      if (gi < 3) begin : g_front
        assign valid_next[gi] = front_next[gi];
      end else begin : g_shift
        assign valid_next[gi] = valid_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= RUN;
      halted_reg    <= 1'b0;
      valid_reg     <= '0;
      stall_cnt_reg <= 3'd0;
      cnt_reg       <= '0;
    end else begin
      valid_reg     <= valid_next;
      stall_cnt_reg <= stall_cnt_next;
      cnt_reg       <= cnt_reg + CNT_W'(valid_reg[NSTAGE-1]);
      case (state_reg)
        RUN: begin
          if (halt_enter) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (valid_reg == '0) begin
            state_reg  <= HALTED;
            halted_reg <= 1'b1;
          end
        end
        HALTED: begin
          if (resume) begin
            state_reg  <= RUN;
            halted_reg <= 1'b0;
          end
        end
        default: begin
          state_reg  <= RUN;
          halted_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: an instruction-occupancy model checked every cycle,
// plus hand-computed expectations for reset, load-use, redirect, halt/drain/resume and wrap.
module tb_pipe_hazard_ctrl;
  localparam int NST = 5;
  localparam int RFA = 5;
  localparam int LL  = 2;
  localparam int CW  = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [RFA-1:0] id_rs1, id_rs2, ex_rd;
  logic           id_use_rs1, id_use_rs2, id_halt, ex_memread, ex_redirect, resume;
  logic           stall_pc, stall_ifid, flush_ifid, bubble_idex, halted, retire;
  logic [NST-1:0] stage_valid;
  logic [CW-1:0]  retire_cnt;

  int checks = 0;
  int errors = 0;

  // model state: instruction id per stage (0 = empty), mode 0=run 1=drain 2=halted
  int occ [NST];
  int mode;
  int stall_left;
  int retired;
  int seq;

  pipe_hazard_ctrl #(
    .NSTAGE(NST), .RF_ADDRESS(RFA), .LOAD_LAT(LL), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_halt(id_halt), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
    .resume(resume), .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid),
    .bubble_idex(bubble_idex), .stage_valid(stage_valid), .halted(halted), .retire(retire),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_halt = 1'b0;
    ex_memread = 1'b0; ex_redirect = 1'b0; resume = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      clear_in();
    end
  endtask

  // Occupancy model, compared on every falling edge.
  initial begin : model
    logic [NST-1:0] e_valid;
    bit haz, lu, go, fetch, e_spc, e_sif, e_fl, e_bub, e_halt, e_ret, rs_hit;
    int left, nmode, nid, e_cnt;
    for (int i = 0; i < NST; i++) occ[i] = 0;
    mode = 0; stall_left = 0; retired = 0; seq = 0;
    forever begin
      @(negedge clk);
      haz = 0; lu = 0; go = 0; left = 0;
      if (!reset) begin
        for (int i = 0; i < NST; i++) occ[i] = 0;
        mode = 0; stall_left = 0; retired = 0;
        e_spc = 0; e_sif = 0; e_fl = 0; e_bub = 0;
      end else begin
        rs_hit = (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
        haz = (occ[1] != 0) && (occ[2] != 0) && ex_memread && (ex_rd != 0) && rs_hit;
        left = stall_left;
        if (haz && left == 0) left = LL;
        lu = (left > 0);
        go = (mode == 0) && (occ[1] != 0) && id_halt && !lu && !ex_redirect;
        e_spc = (mode != 0) || go || (lu && !ex_redirect);
        e_sif = lu && !ex_redirect;
        e_fl  = ex_redirect || go;
        e_bub = ex_redirect || lu;
      end
      for (int i = 0; i < NST; i++) e_valid[i] = (occ[i] != 0);
      e_halt = (mode == 2);
      e_ret  = (occ[NST-1] != 0);
      e_cnt  = retired % (1 << CW);
      check("m_stall_pc", 32'(stall_pc), 32'(e_spc));
      check("m_stall_ifid", 32'(stall_ifid), 32'(e_sif));
      check("m_flush_ifid", 32'(flush_ifid), 32'(e_fl));
      check("m_bubble_idex", 32'(bubble_idex), 32'(e_bub));
      check("m_stage_valid", 32'(stage_valid), 32'(e_valid));
      check("m_halted", 32'(halted), 32'(e_halt));
      check("m_retire", 32'(retire), 32'(e_ret));
      check("m_retire_cnt", 32'(retire_cnt), e_cnt);
      if (reset) begin
        if (occ[NST-1] != 0) retired++;
        nmode = mode;
        if (mode == 0 && go) nmode = 1;
        else if (mode == 1 && e_valid == '0) nmode = 2;
        else if (mode == 2 && resume) nmode = 0;
        fetch = (nmode == 0);
        seq++;
        nid = fetch ? seq : 0;
        for (int i = NST-1; i >= 3; i--) occ[i] = occ[i-1];
        if (ex_redirect) begin
          occ[2] = 0; occ[1] = 0; occ[0] = nid; left = 0;
        end else if (lu) begin
          occ[2] = 0; left--;
        end else if (go) begin
          occ[2] = occ[1]; occ[1] = 0; occ[0] = 0;
        end else begin
          occ[2] = occ[1]; occ[1] = occ[0]; occ[0] = nid;
        end
        stall_left = left;
        mode = nmode;
      end
    end
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [NST-1:0] t1_tab [6];
    int n;
    t1_tab = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};
    reset = 1'b1;
    clear_in();
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t1_rst_valid", 32'(stage_valid), 0);
    check("t1_rst_cnt", 32'(retire_cnt), 0);
    tick();
    reset = 1'b1;
    $display("T1 reset released, filling pipeline");
    for (int k = 0; k <= 22; k++) begin
      @(negedge clk);
      if (k <= 5) check("t1_valid", 32'(stage_valid), 32'(t1_tab[k]));
      if (k == 5) check("t1_retire", 32'(retire), 1);
      if (k == 21) check("t6_cnt_wrap0", 32'(retire_cnt), 0);
      if (k == 22) check("t6_cnt_wrap1", 32'(retire_cnt), 1);
      if (k < 22) tick();
    end

    n = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) begin
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        id_rs2 = 5'd1; id_use_rs2 = 1'b1;
      end
      if (k == 2) clear_in();
      @(negedge clk);
      if (stall_pc && stall_ifid && bubble_idex) n++;
      if (k == 1) check("t2_valid_hold", 32'(stage_valid), 32'(5'b11011));
    end
    check("t2_stall_cycles", n, 2);
    $display("T2 load-use stall cycles=%0d", n);

    tick();
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    @(negedge clk);
    check("t3_x0_nostall", 32'(stall_pc), 0);
    tick();
    ex_rd = 5'd5; id_rs1 = 5'd5; ex_redirect = 1'b1;
    @(negedge clk);
    check("t3_redir_flush", 32'(flush_ifid), 1);
    check("t3_redir_nostall_pc", 32'(stall_pc), 0);
    check("t3_redir_nostall_ifid", 32'(stall_ifid), 0);
    tick();
    clear_in();
    @(negedge clk);
    check("t3_cnt_clear", 32'(stall_pc), 0);
    check("t3_valid_after_redirect", 32'(stage_valid), 32'(5'b11001));
    $display("T3 x0 load and load+redirect");

    tick();
    ex_redirect = 1'b1;
    @(negedge clk);
    check("t4_flush", 32'(flush_ifid), 1);
    check("t4_bubble", 32'(bubble_idex), 1);
    tick();
    clear_in();
    @(negedge clk);
    check("t4_valid", 32'(stage_valid), 32'(5'b00001));
    $display("T4 redirect flush");

    idle(4);
    tick();
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b0;
    id_rs2 = 5'd3; id_use_rs2 = 1'b1;
    @(negedge clk);
    check("t2_rs1_unused", 32'(stall_pc), 0);
    tick();
    id_rs2 = 5'd7;
    @(negedge clk);
    check("t2_rs2_hazard", 32'(stall_pc), 1);
    idle(5);
    $display("T2 rs2 load-use");

    tick();
    ex_memread = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1; id_halt = 1'b1;
    @(negedge clk);
    check("t5_halt_deferred_a", 32'(flush_ifid), 0);
    check("t5_stall_a", 32'(stall_pc), 1);
    tick();
    ex_memread = 1'b0; id_use_rs1 = 1'b0;
    @(negedge clk);
    check("t5_halt_deferred_b", 32'(flush_ifid), 0);
    tick();
    @(negedge clk);
    check("t5_enter_flush", 32'(flush_ifid), 1);
    check("t5_enter_stall_pc", 32'(stall_pc), 1);
    check("t5_enter_nobubble", 32'(bubble_idex), 0);
    for (int j = 1; j <= 8; j++) begin
      tick();
      clear_in();
      if (j == 2 || j == 7) resume = 1'b1;
      @(negedge clk);
      if (j == 3) check("t5_halt_retires", 32'(retire), 1);
      if (j == 4) check("t5_not_yet_halted", 32'(halted), 0);
      if (j == 5) check("t5_halted", 32'(halted), 1);
      if (j == 5) check("t5_drained", 32'(stage_valid), 0);
      if (j == 6) check("t5_halted_stall_pc", 32'(stall_pc), 1);
      if (j == 7) check("t5_halted_at_resume", 32'(halted), 1);
      if (j == 8) check("t5_resumed", 32'(halted), 0);
      if (j == 8) check("t5_refetch", 32'(stage_valid), 32'(5'b00001));
    end
    $display("T5 halt drain resume");

    idle(3);
    tick();
    id_halt = 1'b1; ex_redirect = 1'b1;
    @(negedge clk);
    check("t5_redirect_over_halt", 32'(stall_pc), 0);
    tick();
    clear_in();
    @(negedge clk);
    check("t5_no_drain", 32'(stall_pc), 0);
    $display("T5 redirect beats halt");

    idle(2);
    tick();
    id_halt = 1'b1;
    @(negedge clk);
    check("t6_halt_enter", 32'(flush_ifid), 1);
    tick();
    clear_in();
    tick();
    #2 reset = 1'b0;
    #1;
    check("t6_async_valid", 32'(stage_valid), 0);
    check("t6_async_stall_pc", 32'(stall_pc), 0);
    check("t6_async_cnt", 32'(retire_cnt), 0);
    check("t6_async_halted", 32'(halted), 0);
    @(negedge clk);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("t6_post_valid0", 32'(stage_valid), 0);
    tick();
    @(negedge clk);
    check("t6_post_valid1", 32'(stage_valid), 32'(5'b00001));
    $display("T6 reset during drain");

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
